// File: rtl/chip8_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// chip8_cpu_sequencer : Chip-8 fetch/exec sequencer, PC, return stack, skips.
// Optional macro CHIP8_SEQ_KEYWAIT_EN makes Fx0A stall until key_valid.
// Revision: 1.0
// ============================================================================
module chip8_cpu_sequencer #(
  parameter logic [11:0] PC_RESET    = 12'h200,
  parameter int          STACK_DEPTH = 16
) (
  input  logic        cpu_clk,
  input  logic        reset_n,
  input  logic        run,
  output logic [11:0] mem_addr1,
  output logic [11:0] mem_addr2,
  output logic        fetch_active,
  input  logic [7:0]  mem_readdata1,
  input  logic [7:0]  mem_readdata2,
  input  logic [7:0]  vx_data,
  input  logic [7:0]  vy_data,
  input  logic [7:0]  v0_data,
  input  logic        key_valid,
  output logic [15:0] instruction,
  output logic [3:0]  control,
  output logic        exec_valid,
  output logic [11:0] pc,
  output logic        fault
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] c_sp_full = SP_W'(STACK_DEPTH);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_fetch = 3'd1;
  localparam logic [2:0] c_st_load  = 3'd2;
  localparam logic [2:0] c_st_exec  = 3'd3;
  localparam logic [2:0] c_st_fault = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      w_next_state;
  logic [11:0]     r_pc;
  logic [SP_W-1:0] r_sp;
  logic [15:0]     r_ir;
  logic [3:0]      r_control;
  logic [11:0]     r_stack [STACK_DEPTH];

  logic [3:0]      w_op;
  logic [3:0]      w_x;
  logic [7:0]      w_kk;
  logic [11:0]     w_nnn;
  logic            w_is_call;
  logic            w_is_ret;
  logic            w_is_multi_reg;
  logic            w_is_bcd;
  logic            w_last;
  logic            w_hold_ctrl;
  logic            w_stack_err;
  logic            w_exec_done;
  logic [11:0]     w_pc_plus2;
  logic [11:0]     w_pc_plus4;
  logic [11:0]     w_next_pc;
  logic [SP_W-1:0] w_sp_dec;
  logic [11:0]     w_stack_top;

  assign w_op  = r_ir[15:12];
  assign w_x   = r_ir[11:8];
  assign w_kk  = r_ir[7:0];
  assign w_nnn = r_ir[11:0];

  assign w_is_call      = (w_op == 4'h2);
  assign w_is_ret       = (r_ir == 16'h00EE);
  assign w_is_multi_reg = (w_op == 4'hF) && ((w_kk == 8'h55) || (w_kk == 8'h65));
  assign w_is_bcd       = (w_op == 4'hF) && (w_kk == 8'h33);

`ifdef CHIP8_SEQ_KEYWAIT_EN
  logic w_is_keywait;
  assign w_is_keywait = (w_op == 4'hF) && (w_kk == 8'h0A);
  assign w_hold_ctrl  = w_is_keywait;
`else
  logic w_unused_key;
  assign w_unused_key = key_valid;
  assign w_hold_ctrl  = 1'b0;
`endif

  always_comb begin
    w_last = (r_control == 4'd0);
    if (w_is_multi_reg)
      w_last = (r_control == w_x);
    else if (w_is_bcd)
      w_last = (r_control == 4'd2);
`ifdef CHIP8_SEQ_KEYWAIT_EN
    else if (w_is_keywait)
      w_last = key_valid;
`endif
  end

  assign w_stack_err = (w_is_call && (r_sp == c_sp_full)) ||
                       (w_is_ret  && (r_sp == '0));
  assign w_exec_done = (r_state == c_st_exec) && w_last;

  assign w_pc_plus2  = r_pc + 12'd2;
  assign w_pc_plus4  = r_pc + 12'd4;
  assign w_sp_dec    = r_sp - SP_W'(1);
  assign w_stack_top = r_stack[w_sp_dec[IDX_W-1:0]];

  always_comb begin
    w_next_pc = w_pc_plus2;
    case (w_op)
      4'h0: if (w_is_ret) w_next_pc = w_stack_top;
      4'h1: w_next_pc = w_nnn;
      4'h2: w_next_pc = w_nnn;
      4'h3: if (vx_data == w_kk) w_next_pc = w_pc_plus4;
      4'h4: if (vx_data != w_kk) w_next_pc = w_pc_plus4;
      4'h5: if ((r_ir[3:0] == 4'h0) && (vx_data == vy_data)) w_next_pc = w_pc_plus4;
      4'h9: if ((r_ir[3:0] == 4'h0) && (vx_data != vy_data)) w_next_pc = w_pc_plus4;
      4'hB: w_next_pc = w_nnn + {4'b0, v0_data};
      default: w_next_pc = w_pc_plus2;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= c_st_idle;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:  if (run) w_next_state = c_st_fetch;
      c_st_fetch: w_next_state = c_st_load;
      c_st_load:  w_next_state = c_st_exec;
      c_st_exec: begin
        if (w_last) begin
          if (w_stack_err)
            w_next_state = c_st_fault;
          else if (run)
            w_next_state = c_st_fetch;
          else
            w_next_state = c_st_idle;
        end
      end
      c_st_fault: w_next_state = c_st_fault;
      default:    w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    fetch_active = (r_state == c_st_fetch);
    exec_valid   = (r_state == c_st_exec);
    fault        = (r_state == c_st_fault);
    mem_addr1    = fetch_active ? r_pc : 12'h000;
    mem_addr2    = fetch_active ? (r_pc + 12'd1) : 12'h000;
    instruction  = exec_valid ? r_ir : 16'h0000;
    control      = r_control;
    pc           = r_pc;
  end

  // A stack fault leaves pc and sp untouched; only the state moves to FAULT.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc      <= PC_RESET;
      r_sp      <= '0;
      r_ir      <= 16'h0000;
      r_control <= 4'd0;
    end else begin
      if (r_state == c_st_load) begin
        r_ir      <= {mem_readdata1, mem_readdata2};
        r_control <= 4'd0;
      end
      if (r_state == c_st_exec) begin
        if (w_last) begin
          r_control <= 4'd0;
          if (!w_stack_err) begin
            r_pc <= w_next_pc;
            if (w_is_call)
              r_sp <= r_sp + SP_W'(1);
            else if (w_is_ret)
              r_sp <= w_sp_dec;
          end
        end else if (!w_hold_ctrl) begin
          r_control <= r_control + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (w_exec_done && w_is_call && !w_stack_err)
      r_stack[r_sp[IDX_W-1:0]] <= w_pc_plus2;
  end

endmodule
`default_nettype wire

// File: tb/tb_chip8_cpu_sequencer.sv
`default_nettype none
// Directed self-checking bench for chip8_cpu_sequencer with a 1-cycle-latency
// byte memory model driven from the sequencer's fetch addresses.
module tb_chip8_cpu_sequencer;

  logic        cpu_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  vx_data = 8'h00;
  logic [7:0]  vy_data = 8'h00;
  logic [7:0]  v0_data = 8'h00;
  logic [7:0]  mem_readdata1;
  logic [7:0]  mem_readdata2;
  logic [11:0] mem_addr1;
  logic [11:0] mem_addr2;
  logic        fetch_active;
  logic [15:0] instruction;
  logic [3:0]  control;
  logic        exec_valid;
  logic [11:0] pc;
  logic        fault;

  logic [7:0]  mem [0:4095];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) begin
    mem_readdata1 <= mem[mem_addr1];
    mem_readdata2 <= mem[mem_addr2];
  end

  chip8_cpu_sequencer dut (
    .cpu_clk       (cpu_clk),
    .reset_n       (reset_n),
    .run           (run),
    .mem_addr1     (mem_addr1),
    .mem_addr2     (mem_addr2),
    .fetch_active  (fetch_active),
    .mem_readdata1 (mem_readdata1),
    .mem_readdata2 (mem_readdata2),
    .vx_data       (vx_data),
    .vy_data       (vy_data),
    .v0_data       (v0_data),
    .key_valid     (key_valid),
    .instruction   (instruction),
    .control       (control),
    .exec_valid    (exec_valid),
    .pc            (pc),
    .fault         (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge cpu_clk);
    #1;
  endtask

  task automatic put(input logic [11:0] a, input logic [15:0] op);
    mem[a]         = op[15:8];
    mem[a + 12'd1] = op[7:0];
  endtask

  // Places op at 0x200, pulses reset and returns sampled in the first FETCH.
  task automatic start(input logic [15:0] op);
    put(12'h200, op);
    reset_n = 1'b0;
    run     = 1'b1;
    step(1);
    reset_n = 1'b1;
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

    reset_n = 1'b0;
    step(2);
    chk("rst_pc", pc, 12'h200);
    chk("rst_fetch_active", fetch_active, 1'b0);
    chk("rst_addr1", mem_addr1, 12'h000);
    chk("rst_addr2", mem_addr2, 12'h000);
    chk("rst_exec_valid", exec_valid, 1'b0);
    chk("rst_instruction", instruction, 16'h0000);
    chk("rst_control", control, 4'h0);
    chk("rst_fault", fault, 1'b0);

    // Basic fetch / load / exec
    start(16'h602A);
    chk("f1_fetch_active", fetch_active, 1'b1);
    chk("f1_addr1", mem_addr1, 12'h200);
    chk("f1_addr2", mem_addr2, 12'h201);
    step(1);
    chk("f1_load_exec_valid", exec_valid, 1'b0);
    step(1);
    chk("f1_instruction", instruction, 16'h602A);
    chk("f1_exec_valid", exec_valid, 1'b1);
    chk("f1_control", control, 4'h0);
    step(1);
    chk("f1_next_addr1", mem_addr1, 12'h202);
    chk("f1_next_instruction", instruction, 16'h0000);

    // Conditional skips
    vx_data = 8'h05; start(16'h3A05); step(3);
    chk("skip_3xkk_eq", pc, 12'h204);
    vx_data = 8'h06; start(16'h3A05); step(3);
    chk("skip_3xkk_ne", pc, 12'h202);
    vx_data = 8'h05; start(16'h4A05); step(3);
    chk("skip_4xkk_eq", pc, 12'h202);
    vy_data = 8'h05; start(16'h5120); step(3);
    chk("skip_5xy0_eq", pc, 12'h204);
    vy_data = 8'h06; start(16'h9120); step(3);
    chk("skip_9xy0_ne", pc, 12'h204);

    // Call and return
    put(12'h400, 16'h00EE);
    start(16'h2400); step(3);
    chk("call_pc", pc, 12'h400);
    chk("call_addr1", mem_addr1, 12'h400);
    step(3);
    chk("ret_pc", pc, 12'h202);

    // Return with empty stack
    start(16'h00EE); step(3);
    chk("underflow_fault", fault, 1'b1);
    chk("underflow_pc", pc, 12'h200);
    chk("underflow_fetch", fetch_active, 1'b0);

    // 17 nested calls: the 17th overflows
    put(12'h600, 16'h2600);
    start(16'h2600); step(3);
    repeat (15) step(3);
    chk("ovf16_pc", pc, 12'h600);
    chk("ovf16_fault", fault, 1'b0);
    step(3);
    chk("ovf17_fault", fault, 1'b1);
    chk("ovf17_pc", pc, 12'h600);
    chk("ovf17_exec_valid", exec_valid, 1'b0);
    chk("ovf17_instruction", instruction, 16'h0000);
    step(4);
    chk("ovf_sticky_fault", fault, 1'b1);
    chk("ovf_sticky_pc", pc, 12'h600);

    // Multi-cycle register store/load
    start(16'hF355); step(1);
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("f355_exec_valid", exec_valid, 1'b1);
      chk("f355_control", control, 32'(i));
    end
    step(1);
    chk("f355_done_exec_valid", exec_valid, 1'b0);
    chk("f355_next_addr1", mem_addr1, 12'h202);

    start(16'hFF65); step(1);
    for (int i = 0; i < 16; i++) begin
      step(1);
      chk("ff65_control", control, 32'(i));
    end
    step(1);
    chk("ff65_next_addr1", mem_addr1, 12'h202);
    chk("ff65_fetch_active", fetch_active, 1'b1);

    // BCD: 3 steps
    start(16'hF233); step(1); step(3);
    chk("f233_control", control, 4'h2);
    chk("f233_exec_valid", exec_valid, 1'b1);
    step(1);
    chk("f233_next_pc", pc, 12'h202);

    // Address wrap
    v0_data = 8'h02; start(16'hBFFF); step(3);
    chk("bnnn_wrap_pc", pc, 12'h001);
    put(12'hFFF, 16'h1234);
    start(16'h1FFF); step(3);
    chk("wrap_pc", pc, 12'hFFF);
    chk("wrap_addr1", mem_addr1, 12'hFFF);
    chk("wrap_addr2", mem_addr2, 12'h000);
    step(2);
    chk("wrap_instruction", instruction, 16'h1234);
    step(1);
    chk("wrap_jump_pc", pc, 12'h234);

    // run dropped mid-instruction
    start(16'h602A); step(2);
    run = 1'b0;
    step(1);
    chk("stop_fetch_active", fetch_active, 1'b0);
    chk("stop_pc", pc, 12'h202);
    chk("stop_exec_valid", exec_valid, 1'b0);
    step(3);
    chk("idle_hold_fetch", fetch_active, 1'b0);
    chk("idle_hold_pc", pc, 12'h202);
    run = 1'b1;
    step(1);
    chk("resume_fetch_active", fetch_active, 1'b1);
    chk("resume_addr1", mem_addr1, 12'h202);

    // Asynchronous reset mid-instruction
    put(12'h300, 16'hF555);
    start(16'h1300); step(3);
    chk("pre_reset_pc", pc, 12'h300);
    step(1); step(3);
    chk("pre_reset_control", control, 4'h2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_exec_valid", exec_valid, 1'b0);
    chk("async_rst_control", control, 4'h0);
    chk("async_rst_instruction", instruction, 16'h0000);
    chk("async_rst_pc", pc, 12'h200);
    chk("async_rst_fetch", fetch_active, 1'b0);
    step(1);

    // Fx0A
`ifdef CHIP8_SEQ_KEYWAIT_EN
    key_valid = 1'b0;
    start(16'hF10A); step(2);
    chk("kw_control", control, 4'h0);
    run = 1'b0;
    step(5);
    chk("kw_wait_exec_valid", exec_valid, 1'b1);
    chk("kw_wait_control", control, 4'h0);
    chk("kw_wait_pc", pc, 12'h200);
    key_valid = 1'b1;
    step(1);
    key_valid = 1'b0;
    chk("kw_done_exec_valid", exec_valid, 1'b0);
    chk("kw_done_pc", pc, 12'h202);
    chk("kw_done_idle", fetch_active, 1'b0);
`else
    key_valid = 1'b0;
    start(16'hF10A); step(3);
    chk("f10a_pc", pc, 12'h202);
    chk("f10a_fetch_active", fetch_active, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chip8_cpu_sequencer.md
Name: chip8_cpu_sequencer

Overview:
- Instruction sequencer for the Chip-8 CPU datapath. It fetches the 16-bit opcode from the two byte-wide memory read ports and presents it to the combinational datapath.
- Owns the program counter, the return stack and the skip/jump decisions.
- Drives the per-cycle CONTROL step count for multi-cycle opcodes (Fx55, Fx65, Fx33).
- Sits between program memory and the datapath; the top level muxes memory port addresses using fetch_active.

Parameters:
- PC_RESET, 12'h200, PC value loaded on reset.
- STACK_DEPTH, 16, number of return-stack entries (12 bits each).

Ports:
- cpu_clk  in  1  CPU clock.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  allow new fetches; sampled in IDLE and at instruction end.
- mem_addr1, mem_addr2  out  12  fetch addresses: pc and pc+1 (mod 4096). Zero when not fetching.
- fetch_active  out  1  high in FETCH; top level routes mem_addr1/2 to memory.
- mem_readdata1, mem_readdata2  in  8  opcode bytes (high, low). Synchronous memory, 1-cycle read latency.
- vx_data, vy_data, v0_data  in  8  register values of Vx, Vy, V0 for the current instruction, supplied combinationally by the top level.
- key_valid  in  1  a key is pressed (used only with the optional feature).
- instruction  out  16  opcode to datapath. 16'h0000 outside EXEC.
- control  out  4  step count within EXEC.
- exec_valid  out  1  high during EXEC.
- pc  out  12  current program counter.
- fault  out  1  stack overflow/underflow, sticky.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=PC_RESET, sp=0, control=0, instruction=0, exec_valid=0, fetch_active=0, fault=0, mem_addr1/2=0. Reset mid-instruction aborts it with no PC update.
- States: IDLE, FETCH, LOAD, EXEC, FAULT.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH (1 cycle): fetch_active=1, mem_addr1=pc, mem_addr2=pc+1 (0xFFF+1 wraps to 0x000).
- LOAD (1 cycle): latch ir={mem_readdata1,mem_readdata2}; control=0.
- EXEC: instruction=ir, exec_valid=1. Steps last N cycles, control=0..N-1, incrementing by 1 each cycle:
  - Fx55, Fx65: N=x+1 (x=F gives 16 steps, control ends at 4'hF).
  - Fx33: N=3.
  - All others: N=1.
- Last EXEC cycle computes next_pc, and the next state is FETCH if run=1, else IDLE. Minimum instruction time is 3 cycles.
- next_pc (12-bit, wraps mod 4096), default pc+2. Otherwise:
  - 1nnn: nnn.
  - Bnnn: nnn+{4'b0,v0_data}, truncated to 12 bits.
  - 2nnn: push pc+2, then pc=nnn.
  - 00EE: pop into pc.
  - 3xkk: pc+4 if vx_data==kk.
  - 4xkk: pc+4 if vx_data!=kk.
  - 5xy0: pc+4 if vx_data==vy_data.
  - 9xy0: pc+4 if vx_data!=vy_data.
  - Ex9E / ExA1: default pc+2 (no key-index logic).
  - Undefined opcodes: pc+2, no fault.
- Stack:
  - Push with sp==STACK_DEPTH: overflow. Pop with sp==0: underflow.
  - On either, go to FAULT with fault=1, pc unchanged, no stack change.
  - FAULT holds until reset; instruction=0, exec_valid=0.
- run dropped mid-instruction: the current instruction completes, then IDLE. pc holds the next address; a later run=1 resumes from it.

Optional Feature:
- Macro: CHIP8_SEQ_KEYWAIT_EN.
- Defined: Fx0A holds in EXEC with control=0 until key_valid=1, then completes that cycle (pc+2). run=0 does not abort the wait.
- Undefined: Fx0A is a 1-cycle instruction and key_valid is ignored.

Test Plan:
- Reset, mem returns 0x60,0x2A at 0x200/0x201, run=1 -> FETCH addr 0x200, LOAD, EXEC 1 cycle instruction=0x602A, next fetch at 0x202.
- 0x3A05 with vx_data=0x05 -> next pc=pc+4. With vx_data=0x06 -> pc+2.
- 0x2400 at 0x200, then 0x00EE at 0x400 -> pc 0x400, then 0x202. 17 nested calls -> fault=1 on the 17th, pc frozen.
- 0xF355 -> exec_valid high 4 cycles, control 0,1,2,3, then fetch at pc+2. 0xFF65 -> 16 steps ending at control=0xF.
- 0xBFFF with v0_data=0x02 -> pc=0x001 (wrap). pc=0xFFF fetch -> mem_addr2=0x000.
- Assert reset_n low during step 2 of 0xF555 -> all outputs at reset values immediately, pc=0x200. With CHIP8_SEQ_KEYWAIT_EN: 0xF10A stalls until key_valid pulses, then pc+2.
